// File: rtl/mcs4_pkg.sv
// Shared MCS-4 peripheral constants and small helpers.
package mcs4_pkg;

  localparam int I4003_SR_WIDTH       = 10;
  localparam int I4003_FILTER_DEFAULT = 2;
  localparam logic [3:0] I4003_COUNT_MAX = 4'd15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == I4003_COUNT_MAX) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/mcs4_pad_filter.sv
// Two-flop synchronizer followed by a level filter: the output follows the
// synchronized pad only after FILTER_CYCLES consecutive differing samples.
module mcs4_pad_filter
  import mcs4_pkg::*;
#(
  parameter int FILTER_CYCLES = I4003_FILTER_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic level_o
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Next state: count samples that disagree with the accepted level.
  always_comb begin
    sync_d  = {sync_q[0], pad_i};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == LAST_SAMPLE) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/i4003.sv
// i4003 shift register clocked from filtered pad edges in the sysclk domain.
// Q1 is held in the MSB of the stage vector, Qn in bit 0.
module i4003
  import mcs4_pkg::*;
#(
  parameter int SR_WIDTH      = I4003_SR_WIDTH,
  parameter int FILTER_CYCLES = I4003_FILTER_DEFAULT,
  parameter int SHIFT_ON_FALL = 1
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                cp_pad,
  input  logic                data_in_pad,
  input  logic                e_pad,
  output logic [SR_WIDTH-1:0] parallel_out,
  output logic                serial_out,
  output logic                shift_strobe,
  output logic [3:0]          shift_count
);

  logic cp_filt_s, data_filt_s, e_filt_s;

  mcs4_pad_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_cp_filter (
    .clk_i(sysclk), .rst_i(reset), .pad_i(cp_pad), .level_o(cp_filt_s)
  );
  mcs4_pad_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .clk_i(sysclk), .rst_i(reset), .pad_i(data_in_pad), .level_o(data_filt_s)
  );
  mcs4_pad_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_e_filter (
    .clk_i(sysclk), .rst_i(reset), .pad_i(e_pad), .level_o(e_filt_s)
  );

  logic                cp_prev_q, data_prev_q, e_prev_q;
  logic                strobe_q, strobe_d;
  logic [SR_WIDTH-1:0] sr_q, sr_d;
  logic [3:0]          count_q, count_d;
  logic                shift_s, e_rise_s;

  // Edge detection and next-state; data_prev_q keeps the pre-edge data level.
  always_comb begin
    shift_s  = 1'b0;
    e_rise_s = ~e_prev_q & e_filt_s;
    if (SHIFT_ON_FALL != 0) begin
      shift_s = cp_prev_q & ~cp_filt_s;
    end else begin
      shift_s = ~cp_prev_q & cp_filt_s;
    end

    strobe_d = shift_s;
    sr_d     = sr_q;
    if (shift_s) begin
      sr_d = {data_prev_q, sr_q[SR_WIDTH-1:1]};
    end else begin
      sr_d = sr_q;
    end

    count_d = count_q;
    if (e_rise_s) begin
      count_d = shift_s ? 4'd1 : 4'd0;
    end else if (shift_s) begin
      count_d = sat_inc4(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // State registers; reset overrides any coincident shift.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cp_prev_q   <= 1'b0;
      data_prev_q <= 1'b0;
      e_prev_q    <= 1'b0;
      strobe_q    <= 1'b0;
      sr_q        <= '0;
      count_q     <= 4'd0;
    end else begin
      cp_prev_q   <= cp_filt_s;
      data_prev_q <= data_filt_s;
      e_prev_q    <= e_filt_s;
      strobe_q    <= strobe_d;
      sr_q        <= sr_d;
      count_q     <= count_d;
    end
  end

  assign parallel_out = e_filt_s ? sr_q : '0;
  assign serial_out   = sr_q[0];
  assign shift_strobe = strobe_q;
  assign shift_count  = count_q;

endmodule

// File: tb/tb_i4003.sv
// Randomized self-checking bench for i4003 with a history-based reference model.
module tb_i4003;

  localparam int W   = 10;
  localparam int F   = 2;
  localparam int LAT = 3 + F;

  logic         sysclk = 1'b0;
  logic         reset, cp_pad, data_in_pad, e_pad;
  logic [W-1:0] po1, po2;
  logic         so1, so2, st1, st2;
  logic [3:0]   sc1, sc2;

  int n_checks = 0;
  int n_fail   = 0;

  bit hist[$];
  int m_cnt;
  bit m_en;
  bit pat[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] pat_vec = 10'b1101001101;

  always #5 sysclk = ~sysclk;

  i4003 #(.SR_WIDTH(W), .FILTER_CYCLES(F), .SHIFT_ON_FALL(1)) u_dut_fall (
    .sysclk(sysclk), .reset(reset), .cp_pad(cp_pad), .data_in_pad(data_in_pad),
    .e_pad(e_pad), .parallel_out(po1), .serial_out(so1), .shift_strobe(st1),
    .shift_count(sc1)
  );

  i4003 #(.SR_WIDTH(W), .FILTER_CYCLES(F), .SHIFT_ON_FALL(0)) u_dut_rise (
    .sysclk(sysclk), .reset(reset), .cp_pad(cp_pad), .data_in_pad(data_in_pad),
    .e_pad(e_pad), .parallel_out(po2), .serial_out(so2), .shift_strobe(st2),
    .shift_count(sc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Q1 is the most recent bit, Qk the k-th most recent; Q1 sits in the MSB.
  function automatic logic [W-1:0] exp_stages();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < W; k++) begin
      if (k < hist.size()) v[W-1-k] = hist[hist.size()-1-k];
    end
    return v;
  endfunction

  function automatic logic exp_serial();
    return (hist.size() >= W) ? hist[hist.size()-W] : 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_po"}, po1, m_en ? exp_stages() : '0);
    chk({tag, "_so"}, so1, exp_serial());
    chk({tag, "_cnt"}, sc1, m_cnt);
  endtask

  task automatic model_reset();
    hist.delete();
    m_cnt = 0;
    m_en  = 1'b0;
  endtask

  task automatic rise_phase();
    int lat, n1, n2;
    lat = -1; n1 = 0; n2 = 0;
    cp_pad = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (st2) begin n2++; if (lat < 0) lat = i; end
      if (st1) n1++;
    end
    chk($sformatf("rise_latency(lat=%0d)", lat), (lat >= LAT-1) && (lat <= LAT+1), 1'b1);
    chk("rise_single_strobe", n2, 1);
    chk("rise_no_fall_strobe", n1, 0);
  endtask

  task automatic fall_and_check(input bit exp_bit, input bit d_at_fall);
    int lat, n1, n2;
    lat = -1; n1 = 0; n2 = 0;
    cp_pad      = 1'b0;
    data_in_pad = d_at_fall;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (st1) begin n1++; if (lat < 0) lat = i; end
      if (st2) n2++;
    end
    chk($sformatf("fall_latency(lat=%0d)", lat), (lat >= LAT-1) && (lat <= LAT+1), 1'b1);
    chk("fall_single_strobe", n1, 1);
    chk("fall_no_rise_strobe", n2, 0);
    hist.push_back(exp_bit);
    if (m_cnt < 15) m_cnt++;
    check_outputs("shift");
  endtask

  task automatic do_shift(input bit d, input bit simult);
    data_in_pad = d;
    rise_phase();
    fall_and_check(d, simult ? ~d : d);
  endtask

  task automatic set_en(input bit v);
    e_pad = v;
    repeat (8) step();
    if (v && !m_en) m_cnt = 0;
    m_en = v;
    check_outputs("enable");
  endtask

  initial begin
    int n1, n2;
    reset = 1'b1; cp_pad = 1'b0; data_in_pad = 1'b0; e_pad = 1'b0;
    model_reset();
    repeat (3) step();
    chk("reset_po", po1, 0);
    chk("reset_so", so1, 0);
    chk("reset_strobe", st1, 0);
    chk("reset_cnt", sc1, 0);
    chk("reset_po_rise", po2, 0);
    reset = 1'b0;
    step();

    // Fixed pattern with enable high.
    set_en(1'b1);
    foreach (pat[i]) do_shift(pat[i], 1'b0);
    chk("pattern_po", po1, pat_vec);
    chk("pattern_so", so1, 1'b1);
    chk("pattern_cnt", sc1, 10);

    // One-sysclk cp glitch must be rejected.
    cp_pad = 1'b1;
    step();
    cp_pad = 1'b0;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (st1) n1++;
      if (st2) n2++;
    end
    chk("glitch_no_strobe_fall", n1, 0);
    chk("glitch_no_strobe_rise", n2, 0);
    check_outputs("glitch");

    // Same pattern with enable low, then raise enable.
    reset = 1'b1; e_pad = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    model_reset();
    step();
    foreach (pat[i]) do_shift(pat[i], 1'b0);
    set_en(1'b1);
    chk("enable_rise_po", po1, pat_vec);
    chk("enable_rise_cnt", sc1, 0);

    // Saturation over twenty shifts, including simultaneous data changes.
    for (int i = 0; i < 20; i++) do_shift(1'($urandom_range(1, 0)), ($urandom_range(2, 0) == 0));
    chk("saturate_cnt", sc1, 15);

    // Random mix of shifts and enable toggles.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(3, 0) == 0) set_en(~m_en);
      do_shift(1'($urandom_range(1, 0)), ($urandom_range(2, 0) == 0));
    end
    set_en(1'b1);

    // Reset in the detection cycle, then cp held high across release.
    data_in_pad = 1'b1;
    rise_phase();
    cp_pad = 1'b0;
    repeat (LAT-1) step();
    reset = 1'b1;
    step();
    chk("rst_override_po", po1, 0);
    chk("rst_override_so", so1, 0);
    chk("rst_override_strobe", st1, 0);
    chk("rst_override_cnt", sc1, 0);
    cp_pad = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    model_reset();
    m_en = e_pad;
    n1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (st1) n1++;
    end
    chk("cp_high_release_no_shift", n1, 0);
    fall_and_check(1'b1, 1'b1);
    chk("post_reset_po", po1, 10'b1000000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
